encrypt_function_4_stage: RTL and testbench

Pipelined encryption stage that produces the 78-bit frames consumed by the function-4 decryptor. It accepts 60-bit plaintext words over a valid/ready handshake and draws an 11-bit key word from an internal LFSR. It masks each plaintext with the function-4 pattern and emits `{key, masked word, tag}` on a valid/ready output. It sits directly upstream of the decryptor's `data_1` input.

---
 rtl/encrypt_function_4_stage.sv | 114 +++++++++++
 tb/tb_encrypt_function_4_stage.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encrypt_function_4_stage.sv
// Two-stage encryption pipeline: masks 60-bit plaintext with an LFSR-derived key
// pattern and emits {key, masked word, tag} frames. Optional macro: ENC4_SEQ_TAG_EN.
module encrypt_function_4_stage #(
    parameter logic [10:0] SEED_RESET = 11'h2A5
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [59:0] in_data,
    input  logic        seed_load,
    input  logic [10:0] seed_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [77:0] out_data
);

    localparam int unsigned DATA_W  = 60;
    localparam int unsigned KEY_W   = 11;
    localparam int unsigned TAG_W   = 6;
    localparam int unsigned X_W     = DATA_W + 1;
    localparam int unsigned FRAME_W = KEY_W + X_W + TAG_W;

    logic               s1_valid;
    logic [DATA_W-1:0]  s1_data;
    logic               s1_par;
    logic [KEY_W-1:0]   s1_key;
    logic [KEY_W-1:0]   lfsr;
    logic [TAG_W-1:0]   frame_tag;
    logic [DATA_W-1:0]  mask;
    logic [X_W-1:0]     sum;
    logic [FRAME_W-1:0] frame_next;
    logic               s1_advance;
    logic               accept;

    // S2 is the output register, so S1 may move whenever it is empty or being drained
    assign s1_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign accept     = in_valid && in_ready;

    // Key generator; a seed load overrides the advance, zero seeds map to 1
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            lfsr <= SEED_RESET;
        end else if (seed_load) begin
            lfsr <= (seed_value == '0) ? KEY_W'(1) : seed_value;
        end else if (accept) begin
            lfsr <= {lfsr[9:0], lfsr[10] ^ lfsr[8]};
        end
    end

`ifdef ENC4_SEQ_TAG_EN
    logic [TAG_W-1:0] tag_cnt;
    logic [TAG_W-1:0] s1_tag;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            tag_cnt <= '0;
            s1_tag  <= '0;
        end else if (accept) begin
            tag_cnt <= tag_cnt + TAG_W'(1);
            s1_tag  <= tag_cnt;
        end
    end

    assign frame_tag = s1_tag;
`else
    assign frame_tag = '0;
`endif

    // Stage 1: capture plaintext, its parity and the key current at acceptance
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_par   <= 1'b0;
            s1_key   <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_data  <= in_data;
            s1_par   <= ^in_data;
            s1_key   <= lfsr;
        end else if (s1_advance) begin
            s1_valid <= 1'b0;
        end
    end

    // Mask pattern and modular add; the carry out of the top bit is dropped
    always_comb begin
        mask         = '0;
        mask[10:0]   = s1_key;
        mask[21:11]  = ~s1_key;
        mask[32:22]  = ~s1_key;
        mask[43:33]  = s1_key;
        mask[54:44]  = ~s1_key;
        mask[59:55]  = s1_key[4:0];
        sum          = {s1_data, s1_par} + {1'b0, mask};
        frame_next   = {s1_key, sum, frame_tag};
    end

    // Stage 2: output register, held while the consumer stalls
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (s1_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= frame_next;
            end
        end
    end

endmodule

// File: tb/tb_encrypt_function_4_stage.sv
// Scoreboard bench for encrypt_function_4_stage: a reference key/tag model queues the
// expected frame on every accept and compares it when the frame is handed downstream.
module tb_encrypt_function_4_stage;

    logic        Clk;
    logic        Rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [59:0] in_data;
    logic        seed_load;
    logic [10:0] seed_value;
    logic        out_valid;
    logic        out_ready;
    logic [77:0] out_data;

    encrypt_function_4_stage dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .seed_load  (seed_load),
        .seed_value (seed_value),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [77:0] sb[$];
    logic [10:0] m_lfsr;
    logic [5:0]  m_tag;
    logic [77:0] last_out;
    bit          acc;

    task automatic check(input string tag, input logic [77:0] got, input logic [77:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [59:0] pattern(input logic [10:0] r);
        return {r[4:0], ~r, r, ~r, ~r, r};
    endfunction

    function automatic logic [77:0] exp_frame(input logic [59:0] d, input logic [10:0] r,
                                              input logic [5:0] t);
        logic [60:0] x;
        logic [60:0] y;
        x = {d, ^d};
        y = x + {1'b0, pattern(r)};
        return {r, y, t};
    endfunction

    // Evaluate both handshakes as they will be sampled at the coming edge, then step
    task automatic cycle();
        logic [77:0] e;
        logic [5:0]  tv;
        #1;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 78'(1), 78'(0));
            end else begin
                e = sb.pop_front();
                check("frame", out_data, e);
                check("key_nonzero", 78'(out_data[77:67] == 11'h000), 78'(0));
                last_out = out_data;
            end
        end
        acc = 1'b0;
        if (in_valid && in_ready) begin
`ifdef ENC4_SEQ_TAG_EN
            tv = m_tag;
`else
            tv = 6'd0;
`endif
            sb.push_back(exp_frame(in_data, m_lfsr, tv));
            m_tag = m_tag + 6'd1;
            acc   = 1'b1;
        end
        if (seed_load) begin
            m_lfsr = (seed_value == 11'h000) ? 11'h001 : seed_value;
        end else if (acc) begin
            m_lfsr = {m_lfsr[9:0], m_lfsr[10] ^ m_lfsr[8]};
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        seed_load = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) cycle();
        check("drain_timeout", 78'(sb.size()), 78'(0));
    endtask

    task automatic do_reset();
        Rst_n     = 1'b0;
        in_valid  = 1'b0;
        seed_load = 1'b0;
        sb.delete();
        m_lfsr = 11'h2A5;
        m_tag  = 6'd0;
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
    endtask

    task automatic send_one(input logic [59:0] d);
        in_valid  = 1'b1;
        in_data   = d;
        out_ready = 1'b1;
        cycle();
        in_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [60:0] y;
        logic [60:0] dec;
        logic [77:0] hold;
        int          sent;
        int          n;

        Rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        seed_load  = 1'b0;
        seed_value = '0;
        out_ready  = 1'b0;
        m_lfsr     = 11'h2A5;
        m_tag      = 6'd0;
        last_out   = '0;
        @(negedge Clk);
        #1;
        check("rst_out_valid", 78'(out_valid), 78'(0));
        check("rst_out_data", out_data, 78'(0));
        check("rst_in_ready", 78'(in_ready), 78'(1));
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // First frame after reset: plaintext 0 with the reset key
        send_one(60'h0);
        drain();
        check("first_key", 78'(last_out[77:67]), 78'(11'h2A5));
        check("first_y_10_0", 78'(last_out[16:6]), 78'(11'h2A5));
        check("first_y_21_11", 78'(last_out[27:17]), 78'(11'h55A));
        check("first_y_32_22", 78'(last_out[38:28]), 78'(11'h55A));
        check("first_y_43_33", 78'(last_out[49:39]), 78'(11'h2A5));
        check("first_y_54_44", 78'(last_out[60:50]), 78'(11'h55A));
        check("first_y_59_55", 78'(last_out[65:61]), 78'(5'h05));
        check("first_y_60", 78'(last_out[66]), 78'(0));
        check("first_tag", 78'(last_out[5:0]), 78'(0));

        send_one({$urandom, $urandom});
        drain();
        check("second_key", 78'(last_out[77:67]), 78'(11'h54A));

        // Full LFSR period at one word per cycle
        n = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2200 && n < 2045; i++) begin
            in_data = {$urandom, $urandom};
            cycle();
            if (acc) n++;
        end
        check("period_accepts", 78'(n), 78'(2045));
        send_one(60'h0);
        drain();
        check("period_key", 78'(last_out[77:67]), 78'(11'h2A5));

        // All-ones plaintext: top carry is discarded and decryption restores it
        send_one(60'hFFF_FFFF_FFFF_FFFF);
        drain();
        y   = last_out[66:6];
        dec = y - {1'b0, pattern(last_out[77:67])};
        check("wrap_x", 78'(dec), 78'(61'h1FFF_FFFF_FFFF_FFFE));
        check("wrap_outdec", 78'({1'b0, dec[60:1]}), 78'(61'h0FFF_FFFF_FFFF_FFFF));

        // Back-pressure: downstream stalls for cycles 3..8
        do_reset();
        sent = 0;
        hold = '0;
        for (int c = 0; c < 30 && (sent < 5 || sb.size() != 0); c++) begin
            out_ready = !(c >= 3 && c <= 8);
            in_valid  = (sent < 5);
            in_data   = {$urandom, $urandom};
            #1;
            if (c == 3) hold = out_data;
            if (c >= 3 && c <= 8) begin
                check("stall_in_ready", 78'(in_ready), 78'(0));
                check("stall_out_valid", 78'(out_valid), 78'(1));
                check("stall_out_data", out_data, hold);
            end
            cycle();
            if (acc) sent++;
        end
        check("bp_sent", 78'(sent), 78'(5));
        drain();
`ifdef ENC4_SEQ_TAG_EN
        check("bp_last_tag", 78'(last_out[5:0]), 78'(4));
`else
        check("bp_last_tag", 78'(last_out[5:0]), 78'(0));
`endif

        // Seed load of zero coinciding with an accept
        in_valid   = 1'b1;
        in_data    = {$urandom, $urandom};
        out_ready  = 1'b1;
        seed_load  = 1'b1;
        seed_value = 11'h000;
        cycle();
        seed_load = 1'b0;
        in_data   = {$urandom, $urandom};
        cycle();
        drain();
        check("seed_zero_key", 78'(last_out[77:67]), 78'(11'h001));

        seed_load  = 1'b1;
        seed_value = 11'h123;
        cycle();
        seed_load = 1'b0;
        send_one({$urandom, $urandom});
        drain();
        check("seed_key", 78'(last_out[77:67]), 78'(11'h123));

        // Tag counter wrap: 64 accepts then one more
        do_reset();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && n < 65; i++) begin
            in_data = {$urandom, $urandom};
            cycle();
            if (acc) n++;
        end
        drain();
        check("wrap_tag", 78'(last_out[5:0]), 78'(0));

        // Reset with two frames in flight
        in_valid  = 1'b1;
        out_ready = 1'b0;
        in_data   = {$urandom, $urandom};
        cycle();
        in_data = {$urandom, $urandom};
        cycle();
        in_valid = 1'b0;
        #1;
        check("inflight_out_valid", 78'(out_valid), 78'(1));
        check("inflight_in_ready", 78'(in_ready), 78'(0));
        Rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 78'(out_valid), 78'(0));
        check("midrst_out_data", out_data, 78'(0));
        sb.delete();
        m_lfsr = 11'h2A5;
        m_tag  = 6'd0;
        @(posedge Clk);
        @(negedge Clk);
        Rst_n = 1'b1;
        send_one({$urandom, $urandom});
        drain();
        check("midrst_key", 78'(last_out[77:67]), 78'(11'h2A5));
        check("midrst_tag", 78'(last_out[5:0]), 78'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
